// File: rtl/shift_pattern_detector_if.sv
// Serial detector bus: qualified input bit, live pattern/mask/mode controls,
// and the match pulse, counter, sticky flag and history outputs.
interface shift_pattern_detector_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mask;
    logic             overlap_en;
    logic             clr;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;
    logic             match_seen;
    logic [WIDTH-1:0] save_data;

    modport master (
        output din, din_valid, pattern, mask, overlap_en, clr,
        input  dout, match_cnt, match_seen, save_data
    );

    modport slave (
        input  din, din_valid, pattern, mask, overlap_en, clr,
        output dout, match_cnt, match_seen, save_data
    );
endinterface

// File: rtl/shift_pattern_detector.sv
// Parametrised serial pattern detector with per-bit mask, overlap control,
// saturating match counter and sticky match flag.
module shift_pattern_detector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_pattern_detector_if.slave bus
);
    localparam int FW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] save_q, save_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             dout_q, dout_d;

    logic [WIDTH-1:0] window;
    logic             full;
    logic             hit;

    assign window = {save_q[WIDTH-2:0], bus.din};
    // The window holds only genuine bits once WIDTH-1 are already stored.
    assign full   = (fill_q >= FW'(WIDTH - 1));
    assign hit    = bus.din_valid & full & (((window ^ bus.pattern) & bus.mask) == '0);

    always_comb begin
        save_d = save_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        seen_d = seen_q;
        dout_d = 1'b0;
        if (bus.clr) begin
            save_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (bus.din_valid) begin
            save_d = window;
            if (fill_q != FW'(WIDTH))
                fill_d = fill_q + FW'(1);
            if (hit) begin
                dout_d = 1'b1;
                seen_d = 1'b1;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
                // Non-overlap: history still shifts but the next match needs fresh bits.
                if (!bus.overlap_en)
                    fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            save_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            save_q <= save_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.match_cnt  = cnt_q;
    assign bus.match_seen = seen_q;
    assign bus.save_data  = save_q;
endmodule

// File: tb/tb_shift_pattern_detector.sv
// Bench for shift_pattern_detector: directed scenarios plus random stimulus
// against a bit-history reference model.
module tb_shift_pattern_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shift_pattern_detector_if #(.WIDTH(4), .CNT_W(8)) ia ();
    shift_pattern_detector_if #(.WIDTH(2), .CNT_W(3)) ib ();

    shift_pattern_detector #(.WIDTH(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    shift_pattern_detector #(.WIDTH(2), .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    // Reference model for dut_a: every consumed bit since the last clear, and
    // the index where the current match window may begin.
    bit   hq[$];
    int   start;
    int   m_cnt;
    bit   m_seen;
    bit   m_dout;

    function automatic void model_reset();
        hq.delete();
        start  = 0;
        m_cnt  = 0;
        m_seen = 0;
        m_dout = 0;
    endfunction

    function automatic void model_step(bit d, bit v, bit c, logic [3:0] p, logic [3:0] mk, bit ov);
        m_dout = 0;
        if (c) begin
            model_reset();
        end else if (v) begin
            hq.push_back(d);
            if (hq.size() - start >= 4) begin
                bit ok = 1;
                for (int i = 0; i < 4; i++)
                    if (mk[i] && (hq[hq.size() - 1 - i] != p[i])) ok = 0;
                if (ok) begin
                    m_dout = 1;
                    m_seen = 1;
                    m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (!ov) start = hq.size();
                end
            end
        end
    endfunction

    function automatic logic [3:0] m_save();
        logic [3:0] r = '0;
        for (int j = 0; j < 4; j++)
            if (hq.size() > j) r[j] = hq[hq.size() - 1 - j];
        return r;
    endfunction

    task automatic cyc(input bit d, input bit v, input bit c);
        ia.din = d; ia.din_valid = v; ia.clr = c;
        @(posedge clk); #1;
        model_step(d, v, c, ia.pattern, ia.mask, ia.overlap_en);
        ia.din_valid = 1'b0; ia.clr = 1'b0;
    endtask

    task automatic setup(input logic [3:0] p, input logic [3:0] mk, input bit ov);
        ia.pattern = p; ia.mask = mk; ia.overlap_en = ov;
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        ia.din = 0; ia.din_valid = 0; ia.clr = 0;
        ia.pattern = 4'b1011; ia.mask = 4'b1111; ia.overlap_en = 1;
        ib.din = 0; ib.din_valid = 0; ib.clr = 0;
        ib.pattern = 2'b11; ib.mask = 2'b11; ib.overlap_en = 1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++;
        if ({ia.dout, ia.match_cnt, ia.match_seen, ia.save_data} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs got dout=%b cnt=%0d seen=%b save=%b exp all zero",
                     ia.dout, ia.match_cnt, ia.match_seen, ia.save_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overlap();
        bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
        setup(4'b1011, 4'b1111, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cyc(stream[k], 1'b1, 1'b0);
            total++;
            if (ia.dout !== ((k == 3) || (k == 6))) begin
                bad++;
                $display("FAIL overlap_dout bit%0d got=%b exp=%b", k + 1, ia.dout, (k == 3) || (k == 6));
            end
        end
        total++;
        if (ia.match_cnt !== 8'd2 || ia.match_seen !== 1'b1) begin
            bad++;
            $display("FAIL overlap_cnt got cnt=%0d seen=%b exp cnt=2 seen=1", ia.match_cnt, ia.match_seen);
        end
    endtask

    task automatic test_nonoverlap();
        bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
        setup(4'b1011, 4'b1111, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cyc(stream[k], 1'b1, 1'b0);
            total++;
            if (ia.dout !== (k == 3) || ia.dout !== m_dout) begin
                bad++;
                $display("FAIL nonoverlap_dout bit%0d got=%b exp=%b", k + 1, ia.dout, k == 3);
            end
        end
        total++;
        if (ia.match_cnt !== 8'd1 || ia.save_data !== 4'b1011) begin
            bad++;
            $display("FAIL nonoverlap_final got cnt=%0d save=%b exp cnt=1 save=1011", ia.match_cnt, ia.save_data);
        end
    endtask

    task automatic test_fill_guard();
        bit stream[6] = '{1, 1, 0, 0, 1, 1};
        ia.pattern = 4'b0011; ia.mask = 4'b1111; ia.overlap_en = 1;
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            cyc(stream[k], 1'b1, 1'b0);
            total++;
            if (ia.dout !== (k == 5)) begin
                bad++;
                $display("FAIL fill_guard_dout bit%0d got=%b exp=%b", k + 1, ia.dout, k == 5);
            end
        end
    endtask

    task automatic test_mask();
        logic [3:0] streams[3] = '{4'b1111, 4'b1011, 4'b0111};
        for (int r = 0; r < 3; r++) begin
            logic [3:0] s = streams[r];
            setup(4'b1001, 4'b1001, 1'b1);
            for (int k = 3; k >= 0; k--) cyc(s[k], 1'b1, 1'b0);
            total++;
            if (ia.dout !== (r != 2) || ia.match_cnt !== 8'((r != 2) ? 1 : 0)) begin
                bad++;
                $display("FAIL mask_run%0d got dout=%b cnt=%0d exp dout=%b", r, ia.dout, ia.match_cnt, r != 2);
            end
        end
    endtask

    task automatic test_gaps();
        bit stream[4] = '{1, 0, 1, 1};
        setup(4'b1011, 4'b1111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(stream[k], 1'b1, 1'b0);
            total++;
            if (ia.dout !== (k == 3)) begin
                bad++;
                $display("FAIL gaps_dout valid%0d got=%b exp=%b", k + 1, ia.dout, k == 3);
            end
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'($urandom), 1'b0, 1'b0);
                    total++;
                    if (ia.dout !== 1'b0 || ia.save_data !== m_save()) begin
                        bad++;
                        $display("FAIL gaps_idle got dout=%b save=%b exp dout=0 save=%b", ia.dout, ia.save_data, m_save());
                    end
                end
            end
        end
        total++;
        if (ia.match_cnt !== 8'd1) begin
            bad++;
            $display("FAIL gaps_cnt got=%0d exp=1", ia.match_cnt);
        end
    endtask

    task automatic test_clr_priority();
        setup(4'b1011, 4'b1111, 1'b1);
        cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        cyc(0, 1, 0); cyc(1, 1, 0);
        cyc(1, 1, 1);
        total++;
        if ({ia.dout, ia.match_cnt, ia.match_seen, ia.save_data} !== 14'd0) begin
            bad++;
            $display("FAIL clr_priority got dout=%b cnt=%0d seen=%b save=%b exp all zero",
                     ia.dout, ia.match_cnt, ia.match_seen, ia.save_data);
        end
    endtask

    task automatic test_async_rst();
        setup(4'b1011, 4'b1111, 1'b1);
        cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({ia.dout, ia.match_cnt, ia.match_seen, ia.save_data} !== 14'd0) begin
            bad++;
            $display("FAIL async_rst got dout=%b cnt=%0d seen=%b save=%b exp all zero",
                     ia.dout, ia.match_cnt, ia.match_seen, ia.save_data);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        total++;
        if (ia.dout !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_refill got dout=%b exp=0", ia.dout);
        end
    endtask

    task automatic test_saturation();
        ib.din = 1'b0; ib.din_valid = 1'b0; ib.clr = 1'b1;
        @(posedge clk); #1;
        ib.clr = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            int ec;
            ib.din = 1'b1; ib.din_valid = 1'b1;
            @(posedge clk); #1;
            ec = (k < 2) ? 0 : ((k - 1 > 7) ? 7 : k - 1);
            total++;
            if (ib.dout !== (k >= 2) || ib.match_cnt !== 3'(ec)) begin
                bad++;
                $display("FAIL saturation bit%0d got dout=%b cnt=%0d exp dout=%b cnt=%0d",
                         k, ib.dout, ib.match_cnt, k >= 2, ec);
            end
        end
        ib.din_valid = 1'b0;
    endtask

    task automatic test_random();
        setup(4'b0110, 4'b1111, 1'b1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) ia.pattern    = 4'($urandom);
            if ($urandom_range(0, 19) == 0) ia.mask       = 4'($urandom);
            if ($urandom_range(0, 29) == 0) ia.overlap_en = 1'($urandom);
            cyc(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            total++;
            if (ia.dout !== m_dout || ia.match_cnt !== 8'(m_cnt) ||
                ia.match_seen !== m_seen || ia.save_data !== m_save()) begin
                bad++;
                $display("FAIL random_step%0d got dout=%b cnt=%0d seen=%b save=%b exp dout=%b cnt=%0d seen=%b save=%b",
                         n, ia.dout, ia.match_cnt, ia.match_seen, ia.save_data,
                         m_dout, m_cnt, m_seen, m_save());
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_fill_guard();
        test_mask();
        test_gaps();
        test_clr_priority();
        test_async_rst();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_pattern_detector.md
# shift_pattern_detector

Parametrised serial bit-pattern detector, the generalised successor to the fixed 4-bit shift-register detector. It shifts a qualified serial input into a WIDTH-bit history register and compares the newest WIDTH bits against a runtime-programmable pattern with a per-bit don't-care mask. It supports overlapping and non-overlapping detection, and keeps a saturating match counter plus a sticky match flag. It sits directly behind a serial receive front end and feeds status and interrupt logic.

## Interface
- WIDTH, 4: pattern length in bits; legal range 2..16.
- CNT_W, 8: match counter width; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  qualifies din; a bit is consumed only when high.
- pattern  in  WIDTH  target sequence; pattern[WIDTH-1] is the first-received bit, pattern[0] the last.
- mask  in  WIDTH  1 = compare this bit, 0 = don't care; same bit ordering as pattern.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr  in  1  synchronous clear of history, fill count, counter and sticky flag.
- dout  out  1  one-cycle match pulse (registered).
- match_cnt  out  CNT_W  saturating count of matches.
- match_seen  out  1  sticky flag; set on any match, cleared by clr or rst.
- save_data  out  WIDTH  history register; newest bit in [0], oldest in [WIDTH-1].

## Operation
- Shift: on a din_valid edge, save_data <= {save_data[WIDTH-2:0], din}. With din_valid low, save_data, fill and all outputs except dout hold. dout goes to 0.
- Fill counter: internal, counts consumed bits since the last rst, clr or non-overlap match, and saturates at WIDTH. A match is only possible when the candidate window {save_data[WIDTH-2:0], din} has WIDTH genuine bits, i.e. fill >= WIDTH-1 before the edge. Zero bits left over from reset must never complete a pattern.
- Compare: hit = din_valid & (fill >= WIDTH-1) & ((({save_data[WIDTH-2:0], din}) ^ pattern) & mask) == 0. An all-zero mask matches every window once it is full.
- On hit:
  - dout <= 1.
  - match_cnt increments, holding at 2^CNT_W-1.
  - match_seen <= 1.
- Overlap mode: the history is kept, so the next match may reuse bits from this one.
- Non-overlap mode: on a hit, save_data still shifts, but fill resets to 0. The next match therefore needs WIDTH fresh bits.
- pattern, mask and overlap_en are sampled live every cycle. Changing them mid-stream takes effect on the next compare and does not clear the history.
- clr has priority over din_valid and hit. On a clr edge: save_data=0, fill=0, match_cnt=0, match_seen=0, dout=0. The bit on din that cycle is discarded.
- Reset values: dout=0, match_cnt=0, match_seen=0, save_data=0, fill=0.

## Timing
- Latency is one cycle. If bit N completing the pattern is sampled at edge k, dout is high for the cycle between edges k and k+1.
- dout is never high for two consecutive cycles unless valid bits complete matches on back-to-back edges. This is possible in overlap mode, e.g. pattern 11 on stream 111 gives pulses after bits 2 and 3.
- match_cnt and match_seen update on the same edge as dout rises.
- Asserting rst mid-stream clears every output immediately and asynchronously. After rst deasserts, no match is possible until WIDTH new valid bits have arrived.
- Full throughput: one bit per cycle. No backpressure.

## Test plan
- WIDTH=4, pattern=1011, mask=1111, overlap_en=1; stream 1,0,1,1,0,1,1 with din_valid=1 -> dout pulses after bits 4 and 7; match_cnt=2; match_seen=1.
- Same stream with overlap_en=0 -> a single dout pulse after bit 4; match_cnt=1; save_data after bit 7 = 1011 but no pulse, because fill is 3.
- Reset fill guard: pattern=0011; after rst, apply bits 1,1 -> no dout. Then apply bits 0,0,1,1 -> dout after bit 6.
- Mask: pattern=1001, mask=1001; streams 1111 and 1011 -> both match in separate runs, with clr between runs. Stream 0111 -> no match.
- din_valid gaps: stream 1011 with din_valid low for 3 cycles between each bit, din toggling randomly while invalid -> exactly one pulse, one cycle after the 4th valid edge.
- Saturation and clr priority:
  - CNT_W=3, pattern=11, overlap: nine back-to-back matches -> match_cnt holds 7.
  - Assert clr on the edge that would complete a match -> dout=0, match_cnt=0, match_seen=0.
